uart_tx: RTL and testbench

Serial UART transmitter, 8N1 by default with optional parity and a second stop bit. Accepts bytes over a valid/ready handshake into a one-entry holding register, so a second byte can be queued while the first is on the line. Emits frames on `serial_o` at `CLKS_PER_BIT` clocks per bit. It is the transmit-side counterpart of `uart_rx` and shares its bit timing, so the two loop back directly.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_bit_timer.sv | 26 ++
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, parity modes and frame-size helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_CLEANUP = 3'd5
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Bits on the line for one frame: start + 8 data + optional parity + stops.
  function automatic int unsigned uart_frame_bits(input int unsigned parity,
                                                  input int unsigned stop_bits);
    return 9 + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic logic uart_parity_bit(input logic [7:0] data,
                                           input int unsigned parity);
    return (parity == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit clock divider: counts 0..CLKS_PER_BIT-1 while running, strobes wrap on the last count.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic wrap
);

  localparam int unsigned W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign wrap = run && (count == LAST);

  always_ff @(posedge clk) begin
    if (!resetn || !run || wrap) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register, optional parity and 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       serial_o,
  output logic       busy_o,
  output logic       done_o
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic HAS_PARITY = (PARITY != PAR_NONE);
  localparam logic LAST_STOP  = (STOP_BITS == 2);

  uart_state_e state, state_n;
  logic [7:0]  hold_data;
  logic        ready_q;
  logic [7:0]  shift, shift_n;
  logic [2:0]  bit_idx, bit_n;
  logic        stop_idx, stop_n;
  logic        par_bit, par_n;
  logic        drain, done_n, serial_n;
  logic        accept, wrap;

  // ready_q doubles as "holding register empty"; accept needs it high, drain needs it low.
  assign accept  = valid_i && ready_q;
  assign ready_o = ready_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .resetn(resetn),
    .run   (state != ST_IDLE),
    .wrap  (wrap)
  );

  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    par_n   = par_bit;
    drain   = 1'b0;
    done_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!ready_q) drain = 1'b1;
      end
      ST_START: begin
        if (wrap) begin
          state_n = ST_DATA;
          bit_n   = '0;
        end
      end
      ST_DATA: begin
        if (wrap) begin
          if (bit_idx == 3'd7) begin
            state_n = HAS_PARITY ? ST_PARITY : ST_STOP;
            stop_n  = 1'b0;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = {1'b0, shift[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (wrap) begin
          state_n = ST_STOP;
          stop_n  = 1'b0;
        end
      end
      ST_STOP: begin
        if (wrap) begin
          if (stop_idx == LAST_STOP) begin
            done_n = 1'b1;
            if (!ready_q) drain = 1'b1;
            else          state_n = ST_IDLE;
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Loading is shared by IDLE and the back-to-back path out of STOP.
    if (drain) begin
      shift_n = hold_data;
      par_n   = uart_parity_bit(hold_data, PARITY);
      state_n = ST_START;
    end

    // Line level is registered from the next state so serial_o is glitch-free.
    case (state_n)
      ST_START:  serial_n = 1'b0;
      ST_DATA:   serial_n = shift_n[0];
      ST_PARITY: serial_n = par_n;
      default:   serial_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_bit   <= 1'b0;
      hold_data <= '0;
      ready_q   <= 1'b1;
      serial_o  <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_idx  <= bit_n;
      stop_idx <= stop_n;
      par_bit  <= par_n;
      serial_o <= serial_n;
      busy_o   <= (state_n != ST_IDLE);
      done_o   <= done_n;
      if (accept) begin
        hold_data <= data_i;
        ready_q   <= 1'b0;
      end else if (drain) begin
        ready_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and loopback checks for uart_tx in three parity/stop-bit configurations.
module tb_uart_tx;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data0;
  logic       valid0, ready0, serial0, busy0, done0;
  logic [7:0] data_p;
  logic       valid_p;
  logic       ready_e, serial_e, busy_e, done_e;
  logic       ready_od, serial_od, busy_od, done_od;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .resetn(resetn), .data_i(data0), .valid_i(valid0),
    .ready_o(ready0), .serial_o(serial0), .busy_o(busy0), .done_o(done0));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) dut_even (
    .clk(clk), .resetn(resetn), .data_i(data_p), .valid_i(valid_p),
    .ready_o(ready_e), .serial_o(serial_e), .busy_o(busy_e), .done_o(done_e));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut_odd (
    .clk(clk), .resetn(resetn), .data_i(data_p), .valid_i(valid_p),
    .ready_o(ready_od), .serial_o(serial_od), .busy_o(busy_od), .done_o(done_od));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line levels, bit 0 = start bit, bit 9 = stop bit
  } vec_t;

  vec_t vecs[6];

  logic [7:0] sent_q[$];
  int         rx_count = 0;
  bit         rx_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready0;
    int k = 0;
    while (!ready0 && k < 200) begin
      tick;
      k++;
    end
    check("ready0_wait", ready0, 1'b1);
  endtask

  task automatic send_and_check(input vec_t v);
    data0  = v.data;
    valid0 = 1'b1;
    wait_ready0;
    tick;                                  // accept edge
    valid0 = 1'b0;
    check("hold_full_ready", ready0, 1'b0);
    tick;                                  // start bit begins
    check("ready_after_drain", ready0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      check("frame_bit", serial0, v.frame[c/4]);
      check("busy_in_frame", busy0, 1'b1);
      check("no_early_done", done0, 1'b0);
      tick;
    end
    check("done_pulse", done0, 1'b1);
    check("busy_fall", busy0, 1'b0);
    check("idle_line", serial0, 1'b1);
    tick;
    check("done_single_cycle", done0, 1'b0);
  endtask

  // Receiver model sampling mid-bit; started on the first low level seen at a negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && serial0 === 1'b0) begin
        logic [7:0] b;
        repeat (2) @(negedge clk);
        check("rx_start", serial0, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = serial0;
        end
        repeat (4) @(negedge clk);
        check("rx_stop", serial0, 1'b1);
        n_checks++;
        if (sent_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_unexpected: got byte %0h with nothing sent", b);
        end else begin
          logic [7:0] e;
          e = sent_q.pop_front();
          if (b !== e) begin
            n_fail++;
            $display("FAIL rx_data: got %0h expected %0h", b, e);
          end
          rx_count++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] f1, f2, f3;
    int k;
    valid0 = 1'b0; data0 = '0; valid_p = 1'b0; data_p = '0;
    resetn = 1'b0;
    repeat (3) tick;
    check("rst_serial", serial0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_ready", ready0, 1'b1);
    check("rst_ready_even", ready_e, 1'b1);
    check("rst_serial_odd", serial_od, 1'b1);
    resetn = 1'b1;
    tick;

    vecs[0] = '{data: 8'hA5, frame: 10'h34A};
    vecs[1] = '{data: 8'h00, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[3] = '{data: 8'h3C, frame: 10'h278};
    vecs[4] = '{data: 8'h81, frame: 10'h302};
    vecs[5] = '{data: 8'h5A, frame: 10'h2B4};
    for (int i = 0; i < 6; i++) send_and_check(vecs[i]);

    // Back-to-back 0x00 then 0xFF with valid held high.
    f1 = 10'h200; f2 = 10'h3FE;
    data0 = 8'h00; valid0 = 1'b1;
    wait_ready0;
    tick;
    data0 = 8'hFF;
    check("b2b_hold_full", ready0, 1'b0);
    tick;                                  // c = 0
    check("b2b_ready_e1", ready0, 1'b1);
    check("b2b_start1", serial0, 1'b0);
    tick;                                  // c = 1, second accept
    valid0 = 1'b0;
    for (int c = 1; c < 40; c++) begin
      check("b2b_ready_low", ready0, 1'b0);
      check("b2b_frame1", serial0, f1[c/4]);
      tick;
    end
    check("b2b_ready_drain2", ready0, 1'b1);
    check("b2b_done1", done0, 1'b1);
    check("b2b_no_gap", serial0, 1'b0);
    check("b2b_busy_held", busy0, 1'b1);
    tick;
    for (int c = 41; c < 80; c++) begin
      check("b2b_frame2", serial0, f2[(c-40)/4]);
      check("b2b_no_done", done0, 1'b0);
      check("b2b_busy", busy0, 1'b1);
      tick;
    end
    check("b2b_done2", done0, 1'b1);
    check("b2b_busy_fall", busy0, 1'b0);
    tick;

    // Parity on 0x07: even (2 stops, 48 cycles) and odd (1 stop, 44 cycles) side by side.
    data_p = 8'h07; valid_p = 1'b1;
    k = 0;
    while (!(ready_e && ready_od) && k < 200) begin tick; k++; end
    check("par_ready", ready_e & ready_od, 1'b1);
    tick;
    valid_p = 1'b0;
    tick;
    for (int c = 0; c <= 48; c++) begin
      check("even_done", done_e, (c == 48));
      check("odd_done", done_od, (c == 44));
      check("even_busy", busy_e, (c < 48));
      check("odd_busy", busy_od, (c < 44));
      if (c == 2)  check("even_start", serial_e, 1'b0);
      if (c == 38) check("even_parity_bit", serial_e, 1'b1);
      if (c == 38) check("odd_parity_bit", serial_od, 1'b0);
      if (c == 42 || c == 46) check("even_stop_bits", serial_e, 1'b1);
      tick;
    end

    // Reset during data bit 3 of 0x3C with 0x81 queued.
    f3 = 10'h278;
    data0 = 8'h3C; valid0 = 1'b1;
    wait_ready0;
    tick;
    valid0 = 1'b0;
    tick;                                  // c = 0
    data0 = 8'h81; valid0 = 1'b1;
    check("rst_q_ready", ready0, 1'b1);
    tick;                                  // c = 1, 0x81 accepted
    valid0 = 1'b0;
    check("rst_q_full", ready0, 1'b0);
    for (int c = 1; c < 17; c++) begin
      check("rst_frame", serial0, f3[c/4]);
      tick;
    end
    check("rst_data_bit3", serial0, 1'b1);
    resetn = 1'b0;
    tick;
    check("mid_rst_serial", serial0, 1'b1);
    check("mid_rst_done", done0, 1'b0);
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_ready", ready0, 1'b1);
    tick;
    resetn = 1'b1;
    for (int c = 0; c < 60; c++) begin
      check("post_rst_idle", serial0, 1'b1);
      check("post_rst_no_done", done0, 1'b0);
      check("post_rst_busy", busy0, 1'b0);
      tick;
    end

    // Loopback of 256 random bytes with random valid gaps.
    rx_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      int w;
      repeat ($urandom_range(0, 5)) tick;
      data0  = 8'($urandom);
      valid0 = 1'b1;
      w = 0;
      while (!ready0 && w < 200) begin tick; w++; end
      check("lb_ready", ready0, 1'b1);
      sent_q.push_back(data0);
      tick;
      valid0 = 1'b0;
      check("lb_accept_clears_ready", ready0, 1'b0);
    end
    k = 0;
    while (rx_count < 256 && k < 2000) begin tick; k++; end
    check("lb_rx_count", rx_count, 256);
    check("lb_queue_empty", sent_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
